// File: rtl/spm_pkg.sv
// -----------------------------------------------------------------------------
// spm_pkg
// Shared definitions for the serial-parallel multiplier controller:
//   - spm_state_t : controller FSM states
//   - SPM_CNT_W   : width of the SHIFT-phase cycle counter
//   - default WIDTH / P_LAT values used by spm_ctrl
// -----------------------------------------------------------------------------
package spm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spm_state_t;

    localparam int SPM_WIDTH_DEFAULT = 32;
    localparam int SPM_P_LAT_DEFAULT = 1;

    // The counter walks k = 0 .. 2*width+p_lat-1 during SHIFT.
    function automatic int SPM_CNT_W(input int width, input int p_lat);
        return $clog2(2 * width + p_lat);
    endfunction

endpackage

// File: rtl/spm_shreg.sv
// -----------------------------------------------------------------------------
// spm_shreg
// Right-shifting register with parallel load and serial input at the MSB.
// Serial output is q[0]; parallel output is the whole register.
// Load has priority over shift.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset (clears to zero)
//   load      : load load_data
//   shift_en  : shift right by one, ser_in enters at the MSB
//   load_data : parallel load value
//   ser_in    : serial input bit
//   q         : register contents
// -----------------------------------------------------------------------------
module spm_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] load_data,
    input  logic         ser_in,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] shift_src;
    logic [W-1:0] q_next;

    // Source of each bit on a shift: its upper neighbour, or ser_in at the top.
    assign shift_src[W-1] = ser_in;

    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_src
            assign shift_src[gi] = q_reg[gi + 1];
        end

        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign q_next[gi] = load     ? load_data[gi] :
                                shift_en ? shift_src[gi] :
                                           q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/spm_ctrl.sv
// -----------------------------------------------------------------------------
// spm_ctrl
// Sequencing controller for one serial-parallel multiplier (spm) instance.
// Accepts x/y over a valid/ready request, clears the spm array for one cycle,
// streams the sign/zero-extended y LSB-first for 2*WIDTH cycles (plus P_LAT
// flush cycles), collects the serial product and presents the 2*WIDTH-bit
// result on a valid/ready response.
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid/ready/x/y   : request handshake and operands
//   abort                 : cancel an operation in CLEAR or SHIFT
//   rsp_valid/ready/p     : response handshake and product
//   busy                  : high in CLEAR or SHIFT
//   spm_clr_n/x/y         : drive to the spm array
//   spm_p                 : serial product from the spm array
// -----------------------------------------------------------------------------
module spm_ctrl
    import spm_pkg::*;
#(
    parameter int WIDTH  = SPM_WIDTH_DEFAULT,
    parameter int SIGNED = 1,
    parameter int P_LAT  = SPM_P_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_x,
    input  logic [WIDTH-1:0]   req_y,
    input  logic               abort,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_p,
    output logic               busy,
    output logic               spm_clr_n,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    input  logic               spm_p
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = SPM_CNT_W(WIDTH, P_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PW + P_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_PFIRST = CNT_W'(P_LAT);

    spm_state_t       state_reg;
    spm_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] spm_x_reg;
    logic             spm_y_reg;
    logic             spm_clr_n_reg;
    logic             busy_reg;
    logic             rsp_valid_reg;
    logic [PW-1:0]    rsp_p_reg;

    logic [PW-1:0]    y_ext;
    logic [PW-1:0]    y_q;
    logic [PW-2:0]    p_q;
    logic             y_q_unused;

    logic accept;
    logic in_op;
    logic last_shift;
    logic p_capture;

    generate
        if (SIGNED != 0) begin : g_sext
            assign y_ext = {{WIDTH{req_y[WIDTH-1]}}, req_y};
        end else begin : g_zext
            assign y_ext = {{WIDTH{1'b0}}, req_y};
        end
    endgenerate

    assign accept     = (state_reg == ST_IDLE) && req_valid;
    assign in_op      = (state_reg == ST_CLEAR) || (state_reg == ST_SHIFT);
    assign last_shift = (state_reg == ST_SHIFT) && (cnt_reg == CNT_LAST);
    // Product bit k-P_LAT arrives while the counter reads k.
    assign p_capture  = (state_reg == ST_SHIFT) && (cnt_reg >= CNT_PFIRST) && !abort;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (req_valid) state_next = ST_CLEAR;
            ST_CLEAR: state_next = abort ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: begin
                if (abort)           state_next = ST_IDLE;
                else if (last_shift) state_next = ST_DONE;
            end
            ST_DONE:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // y serializer: loaded at accept, shifts once per CLEAR/SHIFT cycle so that
    // its LSB is always the bit spm_y must show in the following cycle. Zeros
    // shift in from the top, so spm_y falls to 0 once 2*WIDTH bits are out.
    spm_shreg #(.W(PW)) u_y_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift_en  (in_op),
        .load_data (y_ext),
        .ser_in    (1'b0),
        .q         (y_q)
    );

    // Only the LSB of the serializer is consumed.
    assign y_q_unused = ^y_q[PW-1:1];

    // p deserializer holds the low 2*WIDTH-1 product bits; the final MSB comes
    // straight from spm_p when the result register is loaded. Keeping a
    // separate result register leaves rsp_p untouched by an aborted run.
    spm_shreg #(.W(PW - 1)) u_p_deser (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .shift_en  (p_capture),
        .load_data ('0),
        .ser_in    (spm_p),
        .q         (p_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            spm_x_reg     <= '0;
            spm_y_reg     <= 1'b0;
            spm_clr_n_reg <= 1'b1;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_p_reg     <= '0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                spm_x_reg <= req_x;
                cnt_reg   <= '0;
            end else if ((state_reg == ST_SHIFT) && !abort && !last_shift) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            // Registered outputs are decoded from the next state so they line
            // up with the state they describe.
            spm_clr_n_reg <= (state_next != ST_CLEAR);
            busy_reg      <= (state_next == ST_CLEAR) || (state_next == ST_SHIFT);
            rsp_valid_reg <= (state_next == ST_DONE);
            spm_y_reg     <= (state_next == ST_SHIFT) ? y_q[0] : 1'b0;

            if (last_shift && !abort) begin
                rsp_p_reg <= {spm_p, p_q};
            end
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_p     = rsp_p_reg;
    assign busy      = busy_reg;
    assign spm_clr_n = spm_clr_n_reg;
    assign spm_x     = spm_x_reg;
    assign spm_y     = spm_y_reg;

endmodule

// File: tb/tb_spm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spm_ctrl
// Two controllers (unsigned and signed, WIDTH=8, P_LAT=1) share one stimulus
// stream; each drives a behavioural serial multiplier. Results are compared
// with products computed directly from the operands.
// -----------------------------------------------------------------------------
module tb_spm_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [7:0]  req_x;
    logic [7:0]  req_y;
    logic        abort;
    logic        rsp_ready;

    logic        req_ready_u, rsp_valid_u, busy_u, spm_clr_n_u, spm_y_u, spm_p_u;
    logic [15:0] rsp_p_u;
    logic [7:0]  spm_x_u;
    logic        req_ready_s, rsp_valid_s, busy_s, spm_clr_n_s, spm_y_s, spm_p_s;
    logic [15:0] rsp_p_s;
    logic [7:0]  spm_x_s;

    int checks = 0;
    int errors = 0;

    spm_ctrl #(.WIDTH(8), .SIGNED(0), .P_LAT(1)) dut_u (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_u),
        .req_x(req_x), .req_y(req_y), .abort(abort), .rsp_valid(rsp_valid_u),
        .rsp_ready(rsp_ready), .rsp_p(rsp_p_u), .busy(busy_u),
        .spm_clr_n(spm_clr_n_u), .spm_x(spm_x_u), .spm_y(spm_y_u), .spm_p(spm_p_u)
    );

    spm_ctrl #(.WIDTH(8), .SIGNED(1), .P_LAT(1)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_x(req_x), .req_y(req_y), .abort(abort), .rsp_valid(rsp_valid_s),
        .rsp_ready(rsp_ready), .rsp_p(rsp_p_s), .busy(busy_s),
        .spm_clr_n(spm_clr_n_s), .spm_x(spm_x_s), .spm_y(spm_y_s), .spm_p(spm_p_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural serial multiplier: accumulates x*ybit, emits the LSB one
    // cycle later and keeps the rest as carry. x is extended to 16 bits.
    logic [31:0] acc_u_reg, acc_s_reg, xs_u, xs_s, sum_u, sum_s;
    logic        p_u_reg, p_s_reg;
    assign xs_u  = {24'b0, spm_x_u};
    assign xs_s  = {16'b0, {8{spm_x_s[7]}}, spm_x_s};
    assign sum_u = acc_u_reg + (spm_y_u ? xs_u : 32'd0);
    assign sum_s = acc_s_reg + (spm_y_s ? xs_s : 32'd0);
    assign spm_p_u = p_u_reg;
    assign spm_p_s = p_s_reg;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_u_reg <= 0; p_u_reg <= 1'b0;
        end else if (!spm_clr_n_u) begin
            acc_u_reg <= 0; p_u_reg <= 1'b0;
        end else begin
            p_u_reg <= sum_u[0]; acc_u_reg <= sum_u >> 1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_s_reg <= 0; p_s_reg <= 1'b0;
        end else if (!spm_clr_n_s) begin
            acc_s_reg <= 0; p_s_reg <= 1'b0;
        end else begin
            p_s_reg <= sum_s[0]; acc_s_reg <= sum_s >> 1;
        end
    end

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        int a, b, p;
        if (sgn) begin
            a = int'($signed(x));
            b = int'($signed(y));
        end else begin
            a = int'(x);
            b = int'(y);
        end
        p = a * b;
        return p[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, {req_ready_u, req_ready_s}, 2'b11);
        check({tag, " rsp_valid"}, {rsp_valid_u, rsp_valid_s}, 2'b00);
        check({tag, " busy"},      {busy_u, busy_s}, 2'b00);
        check({tag, " spm_clr_n"}, {spm_clr_n_u, spm_clr_n_s}, 2'b11);
        check({tag, " spm_y"},     {spm_y_u, spm_y_s}, 2'b00);
        check({tag, " spm_x"},     {spm_x_u, spm_x_s}, 16'h0);
        check({tag, " rsp_p"},     {rsp_p_u, rsp_p_s}, 32'h0);
    endtask

    // One multiply: wait for ready, request, measure latency, compare product.
    // With release_rsp=0 the controllers are left in DONE.
    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp_u, input logic [15:0] exp_s,
                          input bit release_rsp);
        int n;
        n = 0;
        while (!(req_ready_u && req_ready_s) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " req_ready"}, {req_ready_u, req_ready_s}, 2'b11);
        req_x = x; req_y = y; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " busy"}, {busy_u, busy_s, spm_clr_n_u, spm_clr_n_s}, 4'b1100);
        n = 1;
        while (!(rsp_valid_u || rsp_valid_s) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " rsp_valid"}, {rsp_valid_u, rsp_valid_s}, 2'b11);
        check({tag, " latency"}, n, 19);
        check({tag, " rsp_p_u"}, rsp_p_u, exp_u);
        check({tag, " rsp_p_s"}, rsp_p_s, exp_s);
        check({tag, " spm_x"}, {spm_x_u, spm_x_s}, {x, x});
        $display("op %s x=%h y=%h p_u=%h p_s=%h latency=%0d", tag, x, y, rsp_p_u, rsp_p_s, n);
        if (release_rsp) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check({tag, " rsp_done"}, {rsp_valid_u, rsp_valid_s, req_ready_u, req_ready_s}, 4'b0011);
        end
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_u, hold_s;
        logic [7:0]  rx, ry;
        bit          seen;

        vecs[0] = '{x: 8'h03, y: 8'h05, exp_u: 16'h000F, exp_s: 16'h000F};
        vecs[1] = '{x: 8'hFD, y: 8'h05, exp_u: 16'h04F1, exp_s: 16'hFFF1};
        vecs[2] = '{x: 8'h80, y: 8'h80, exp_u: 16'h4000, exp_s: 16'h4000};
        vecs[3] = '{x: 8'h07, y: 8'h09, exp_u: 16'h003F, exp_s: 16'h003F};
        vecs[4] = '{x: 8'hFF, y: 8'hFF, exp_u: 16'hFE01, exp_s: 16'h0001};

        rst = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
        abort = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp_u, vecs[i].exp_s, 1'b1);
        end

        // Backpressure: hold rsp_ready low, then release with a request waiting
        run_op("hold", 8'h2B, 8'hC7, ref_mul(8'h2B, 8'hC7, 0), ref_mul(8'h2B, 8'hC7, 1), 1'b0);
        hold_u = rsp_p_u; hold_s = rsp_p_s;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold valid", {rsp_valid_u, rsp_valid_s, req_ready_u, req_ready_s}, 4'b1100);
            check("hold stable", {rsp_p_u, rsp_p_s}, {hold_u, hold_s});
        end
        rsp_ready = 1'b1; req_valid = 1'b1; req_x = 8'h11; req_y = 8'h0F;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("release no bypass", {rsp_valid_u, rsp_valid_s, busy_u, busy_s, req_ready_u, req_ready_s}, 6'b000011);
        run_op("after_hold", 8'h11, 8'h0F, 16'h00FF, 16'h00FF, 1'b1);

        // Abort in DONE is ignored
        run_op("done_abort", 8'h9C, 8'h35, ref_mul(8'h9C, 8'h35, 0), ref_mul(8'h9C, 8'h35, 1), 1'b0);
        hold_u = rsp_p_u; hold_s = rsp_p_s;
        abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        check("done abort ignored", {rsp_valid_u, rsp_valid_s, rsp_p_u, rsp_p_s}, {2'b11, hold_u, hold_s});
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Abort at SHIFT k=6
        req_x = 8'hA5; req_y = 8'h5A; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        repeat (6) @(posedge clk);
        #1;
        abort = 1'b1;
        check("abort busy", {busy_u, busy_s}, 2'b11);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort idle", {req_ready_u, req_ready_s, busy_u, busy_s, spm_clr_n_u, spm_clr_n_s, spm_y_u, spm_y_s}, 8'b11001100);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_u || rsp_valid_s) seen = 1'b1;
        end
        check("abort no rsp", seen, 1'b0);
        check("abort rsp_p kept", {rsp_p_u, rsp_p_s}, {hold_u, hold_s});
        $display("op abort x=a5 y=5a rsp_valid_seen=%0d", seen);
        run_op("post_abort", 8'h07, 8'h09, 16'h003F, 16'h003F, 1'b1);

        // Reset in the middle of SHIFT
        req_x = 8'h5E; req_y = 8'hE3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        $display("op midreset x=5e y=e3 aborted by reset");
        run_op("post_reset", 8'hFF, 8'hFF, 16'hFE01, 16'h0001, 1'b1);

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 30; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            run_op($sformatf("rnd%0d", i), rx, ry, ref_mul(rx, ry, 0), ref_mul(rx, ry, 1), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
